// File: rtl/osc_cmd_pkg.sv
// Purpose : shared command bytes, client ids, sequencer states and command decode.
// Latency : n/a (types, constants and a pure combinational helper).
// Backpressure : n/a.
package osc_cmd_pkg;

   localparam int N_CLIENTS = 3;

   // UART command bytes ('C', 'S', 'R')
   localparam logic [7:0] CMD_CLEAR   = 8'h43;
   localparam logic [7:0] CMD_CAPTURE = 8'h53;
   localparam logic [7:0] CMD_READ    = 8'h52;

   // Client ids, also the slice index into the per-client buses
   localparam logic [1:0] ID_CLEAR   = 2'd0;
   localparam logic [1:0] ID_CAPTURE = 2'd1;
   localparam logic [1:0] ID_READ    = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   typedef struct packed {
      logic       known;
      logic [1:0] id;
   } cmd_dec_t;

   function automatic cmd_dec_t decode_cmd(input logic [7:0] b);
      cmd_dec_t d;
      d.known = 1'b1;
      d.id    = ID_CLEAR;
      case (b)
         CMD_CLEAR:   d.id = ID_CLEAR;
         CMD_CAPTURE: d.id = ID_CAPTURE;
         CMD_READ:    d.id = ID_READ;
         default:     d.known = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/task_watchdog.sv
// Purpose : counts cycles a task has held the RAM port; pulses expired on the last allowed cycle.
// Latency : expired_o is combinational from the counter (asserted during cycle TIMEOUT_CYCLES of a run).
// Backpressure : none; counter saturates instead of wrapping.
// Ports: clk_50mhz/reset (sync, active-high), clear_i zeroes the count, run_i counts up,
//        expired_o high while running with count == TIMEOUT_CYCLES-1 (never when TIMEOUT_CYCLES == 0).
module task_watchdog #(
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic clk_50mhz,
   input  logic reset,
   input  logic clear_i,
   input  logic run_i,
   output logic expired_o
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic          ENABLED  = (TIMEOUT_CYCLES > 0);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (run_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = ENABLED & run_i & ~clear_i & (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_task_sequencer.sv
// Purpose : decodes UART commands, grants the single sample-RAM port to one task module at a time.
// Latency : activate/busy one cycle after the command byte; RAM mux and rx forwarding are combinational.
// Backpressure : none; bytes arriving outside ACTIVE that are not commands are dropped.
// Ports: rx_data/rx_ready from the UART; cli_* per-task handshake and RAM request buses (client i at
//        slice i); mem_* shared RAM port; busy/owner status; err_unknown/err_timeout one-cycle pulses.
module mem_task_sequencer #(
   parameter int SAMPLE_DEPTH   = 8,
   parameter int WIDTH          = 8,
   parameter int N_CLIENTS      = osc_cmd_pkg::N_CLIENTS,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                              clk_50mhz,
   input  logic                              reset,
   input  logic [7:0]                        rx_data,
   input  logic                              rx_ready,
   output logic [N_CLIENTS-1:0]              cli_activate,
   input  logic [N_CLIENTS-1:0]              cli_done,
   output logic [N_CLIENTS-1:0]              cli_rx_ready,
   input  logic [N_CLIENTS*WIDTH-1:0]        cli_mem_data,
   input  logic [N_CLIENTS*SAMPLE_DEPTH-1:0] cli_mem_addr,
   input  logic [N_CLIENTS-1:0]              cli_mem_we,
   input  logic [N_CLIENTS-1:0]              cli_mem_en,
   output logic [WIDTH-1:0]                  mem_data,
   output logic [SAMPLE_DEPTH-1:0]           mem_addr,
   output logic                              mem_we,
   output logic                              mem_en,
   output logic                              busy,
   output logic [1:0]                        owner,
   output logic                              err_unknown,
   output logic                              err_timeout
);

   import osc_cmd_pkg::*;

   state_t     state_q, state_d;
   logic [1:0] owner_q, owner_d;
   logic       err_unknown_q, err_unknown_d;
   logic       err_timeout_q, err_timeout_d;

   cmd_dec_t                cmd;
   logic [N_CLIENTS-1:0]    own_sel;
   logic                    done_own;
   logic [WIDTH-1:0]        own_data;
   logic [SAMPLE_DEPTH-1:0] own_addr;
   logic                    own_we;
   logic                    own_en;
   logic                    expired;
   logic                    in_active;

   assign cmd       = decode_cmd(rx_data);
   assign in_active = (state_q == ST_ACTIVE);

   // Select the owner's slice of every per-client bus. The owner register only
   // ever holds a decoded id, so exactly one bit of own_sel is set.
   always_comb begin
      own_sel  = '0;
      done_own = 1'b0;
      own_data = '0;
      own_addr = '0;
      own_we   = 1'b0;
      own_en   = 1'b0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (owner_q == 2'(i)) begin
            own_sel[i] = 1'b1;
            done_own   = cli_done[i];
            own_data   = cli_mem_data[i*WIDTH +: WIDTH];
            own_addr   = cli_mem_addr[i*SAMPLE_DEPTH +: SAMPLE_DEPTH];
            own_we     = cli_mem_we[i];
            own_en     = cli_mem_en[i];
         end
      end
   end

   task_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_50mhz (clk_50mhz),
      .reset     (reset),
      .clear_i   (~in_active),
      .run_i     (in_active),
      .expired_o (expired)
   );

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      err_unknown_d = 1'b0;
      err_timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_ready) begin
               if (cmd.known) begin
                  owner_d = cmd.id;
                  state_d = ST_ACTIVE;
               end else begin
                  err_unknown_d = 1'b1;
               end
            end
         end
         ST_ACTIVE: begin
            // A done arriving on the last allowed cycle is a clean finish.
            if (done_own) begin
               state_d = ST_RELEASE;
            end else if (expired) begin
               state_d       = ST_RELEASE;
               err_timeout_d = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (!done_own) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         owner_q       <= ID_CLEAR;
         err_unknown_q <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         err_unknown_q <= err_unknown_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   // Activate follows the registered state so it falls on the edge that
   // leaves ACTIVE (including the reset edge). The RAM port, forwarding and
   // busy are also forced low while reset is held.
   always_comb begin
      cli_activate = in_active ? own_sel : '0;
      cli_rx_ready = '0;
      mem_data     = '0;
      mem_addr     = '0;
      mem_we       = 1'b0;
      mem_en       = 1'b0;
      busy         = 1'b0;
      if (!reset) begin
         busy = (state_q != ST_IDLE);
         if (in_active) begin
            cli_rx_ready = own_sel & {N_CLIENTS{rx_ready}};
            mem_data     = own_data;
            mem_addr     = own_addr;
            mem_we       = own_we;
            mem_en       = own_en;
         end
      end
   end

   assign owner       = owner_q;
   assign err_unknown = err_unknown_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mem_task_sequencer.sv
module tb_mem_task_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_ready;

   // client 0: behavioural memory-clear task
   logic        cl_run, cl_we, cl_done;
   logic [7:0]  cl_addr, cl_fill;
   // clients 1 and 2: driven directly by the stimulus
   logic        c1_we, c1_en, c1_done, c2_we, c2_en, c2_done;
   logic [7:0]  c1_addr, c1_data, c2_addr, c2_data;

   logic [2:0]  cli_done, cli_mem_we, cli_mem_en;
   logic [23:0] cli_mem_data, cli_mem_addr;

   // main DUT (long timeout) and timeout DUT (TIMEOUT_CYCLES=100)
   logic [2:0]  act_m, rxr_m, act_t, rxr_t;
   logic [7:0]  md_m, ma_m, md_t, ma_t;
   logic        mwe_m, men_m, busy_m, eu_m, et_m;
   logic        mwe_t, men_t, busy_t, eu_t, et_t;
   logic [1:0]  own_m, own_t;

   int          n_chk = 0;
   int          n_err = 0;
   logic        mon_on;
   logic [15:0] exp_wr[$];

   assign cli_done     = {c2_done, c1_done, cl_done};
   assign cli_mem_we   = {c2_we, c1_we, cl_we};
   assign cli_mem_en   = {c2_en, c1_en, cl_we};
   assign cli_mem_data = {c2_data, c1_data, cl_fill};
   assign cli_mem_addr = {c2_addr, c1_addr, cl_addr};

   always #5 clk = ~clk;

   mem_task_sequencer #(.SAMPLE_DEPTH(8), .WIDTH(8), .N_CLIENTS(3), .TIMEOUT_CYCLES(400)) dut (
      .clk_50mhz(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
      .cli_activate(act_m), .cli_done(cli_done), .cli_rx_ready(rxr_m),
      .cli_mem_data(cli_mem_data), .cli_mem_addr(cli_mem_addr),
      .cli_mem_we(cli_mem_we), .cli_mem_en(cli_mem_en),
      .mem_data(md_m), .mem_addr(ma_m), .mem_we(mwe_m), .mem_en(men_m),
      .busy(busy_m), .owner(own_m), .err_unknown(eu_m), .err_timeout(et_m));

   mem_task_sequencer #(.SAMPLE_DEPTH(8), .WIDTH(8), .N_CLIENTS(3), .TIMEOUT_CYCLES(100)) dut_to (
      .clk_50mhz(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
      .cli_activate(act_t), .cli_done(cli_done), .cli_rx_ready(rxr_t),
      .cli_mem_data(cli_mem_data), .cli_mem_addr(cli_mem_addr),
      .cli_mem_we(cli_mem_we), .cli_mem_en(cli_mem_en),
      .mem_data(md_t), .mem_addr(ma_t), .mem_we(mwe_t), .mem_en(men_t),
      .busy(busy_t), .owner(own_t), .err_unknown(eu_t), .err_timeout(et_t));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory-clear task: first forwarded byte is the fill value, then one
   // write per cycle over addresses 0..255, then done until activate drops.
   always @(posedge clk) begin
      if (reset || !act_m[0]) begin
         cl_run  <= 1'b0;
         cl_we   <= 1'b0;
         cl_done <= 1'b0;
         cl_addr <= 8'h00;
         cl_fill <= 8'h00;
      end else if (!cl_done) begin
         if (!cl_run) begin
            if (rxr_m[0]) begin
               cl_fill <= rx_data;
               cl_addr <= 8'h00;
               cl_run  <= 1'b1;
               cl_we   <= 1'b1;
            end
         end else if (cl_addr == 8'hFF) begin
            cl_run  <= 1'b0;
            cl_we   <= 1'b0;
            cl_done <= 1'b1;
         end else begin
            cl_addr <= cl_addr + 8'd1;
         end
      end
   end

   // Invariants every cycle, and RAM writes against the scoreboard.
   always @(negedge clk) begin
      logic [31:0] exp;
      check("act_onehot_m", 32'($onehot0(act_m)), 32'd1);
      check("act_onehot_t", 32'($onehot0(act_t)), 32'd1);
      check("we_only_busy", 32'(mwe_m & ~busy_m), 32'd0);
      if (mon_on && mwe_m && men_m) begin
         exp = 32'hFFFF_FFFF;
         if (exp_wr.size() != 0) exp = {16'h0, exp_wr.pop_front()};
         check("ram_write", {16'h0, ma_m, md_m}, exp);
      end
   end

   task automatic send(input logic [7:0] b, output logic [2:0] fwd);
      @(negedge clk);
      rx_data  = b;
      rx_ready = 1'b1;
      #1 fwd = rxr_m;
      @(negedge clk);
      rx_ready = 1'b0;
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL sim_limit: simulation time limit reached");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [2:0] fwd;
      int         n;
      reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; mon_on = 1'b1;
      c1_we = 0; c1_en = 0; c1_done = 0; c1_addr = 0; c1_data = 0;
      c2_we = 0; c2_en = 0; c2_done = 0; c2_addr = 0; c2_data = 0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_act",   32'(act_m), 32'd0);
      check("rst_busy",  32'(busy_m), 32'd0);
      check("rst_owner", 32'(own_m), 32'd0);
      check("rst_err",   32'({eu_m, et_m}), 32'd0);
      check("rst_mem",   {12'h0, mwe_m, men_m, ma_m, md_m}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // unknown byte in IDLE
      send(8'h7E, fwd);
      check("unk_pulse", 32'(eu_m), 32'd1);
      check("unk_act",   32'(act_m), 32'd0);
      check("unk_busy",  32'(busy_m), 32'd0);
      check("unk_fwd",   32'(fwd), 32'd0);
      @(negedge clk); #1;
      check("unk_pulse_end", 32'(eu_m), 32'd0);
      check("unk_busy2",     32'(busy_m), 32'd0);

      // 'C': clear task owns the port
      send(8'h43, fwd);
      check("c_cmd_not_fwd", 32'(fwd), 32'd0);
      check("c_act",   32'(act_m), 32'b001);
      check("c_busy",  32'(busy_m), 32'd1);
      check("c_owner", 32'(own_m), 32'd0);

      // non-owner write/done while client 0 owns the port and is not writing
      @(negedge clk);
      c1_we = 1; c1_en = 1; c1_addr = 8'h99; c1_data = 8'h5A; c1_done = 1;
      repeat (3) begin
         @(negedge clk); #1;
         check("stray_mem",  32'({mwe_m, men_m, ma_m, md_m}), 32'd0);
         check("stray_act",  32'(act_m), 32'b001);
         check("stray_busy", 32'(busy_m), 32'd1);
      end
      c1_we = 0; c1_en = 0; c1_addr = 0; c1_data = 0; c1_done = 0;

      // fill byte 0xA5: expect writes of 0xA5 to addresses 0..255
      for (int a = 0; a < 256; a++) exp_wr.push_back({8'(a), 8'hA5});
      send(8'hA5, fwd);
      check("fill_fwd", 32'(fwd), 32'b001);
      repeat (50) @(negedge clk);
      send(8'h53, fwd);
      check("s_fwd_owner", 32'(fwd), 32'b001);
      check("s_owner",     32'(own_m), 32'd0);
      check("s_act",       32'(act_m), 32'b001);

      n = 0;
      while (!cl_done && n < 400) begin
         @(negedge clk);
         n++;
      end
      #1;
      check("clr_done_seen", 32'(cl_done), 32'd1);
      check("clr_act_at_done", 32'(act_m), 32'b001);
      check("clr_writes_left", 32'(exp_wr.size()), 32'd0);
      @(negedge clk); #1;
      check("rel_act",  32'(act_m), 32'd0);
      check("rel_busy", 32'(busy_m), 32'd1);
      check("rel_no_to", 32'(et_m), 32'd0);
      @(negedge clk); #1;
      check("rel_busy2", 32'(busy_m), 32'd1);
      @(negedge clk); #1;
      check("idle_busy", 32'(busy_m), 32'd0);

      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;

      // 'R' with a task that never finishes: 100-cycle timeout on dut_to
      mon_on = 1'b0;
      c2_we = 1; c2_en = 1; c2_addr = 8'h3C; c2_data = 8'hC3;
      send(8'h52, fwd);
      check("r_act_t", 32'(act_t), 32'b100);
      check("r_mux_t", 32'({mwe_t, men_t, ma_t, md_t}), {14'h0, 2'b11, 16'h3CC3});
      n = 0;
      while (act_t[2] && n < 200) begin
         n++;
         @(negedge clk); #1;
      end
      check("to_len",      32'(n), 32'd100);
      check("to_err",      32'(et_t), 32'd1);
      check("to_we_after", 32'(mwe_t), 32'd0);
      check("to_owner",    32'(own_t), 32'd2);
      check("to_main_act", 32'(act_m), 32'b100);
      @(negedge clk); #1;
      check("to_err_end",   32'(et_t), 32'd0);
      check("to_mem_after", 32'({mwe_t, men_t}), 32'd0);

      // reset while main DUT is active with a writing client
      check("m_we_active", 32'(mwe_m), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_hold",      32'({busy_m, mwe_m, men_m, ma_m, md_m}), 32'd0);
      check("rst_act_still", 32'(act_m), 32'b100);
      @(negedge clk); #1;
      check("rst_act_drop",  32'(act_m), 32'd0);
      reset = 1'b0;
      c2_we = 0; c2_en = 0; c2_addr = 0; c2_data = 0;

      // reset mid-clear at address 0x40, then 'S' accepted
      mon_on = 1'b1;
      send(8'h43, fwd);
      for (int a = 0; a < 256; a++) exp_wr.push_back({8'(a), 8'h11});
      send(8'h11, fwd);
      n = 0;
      while (!(cl_we === 1'b1 && cl_addr === 8'h40) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("mid_reach", 32'(cl_addr), 32'h40);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk); #1;
      check("mid_busy",      32'(busy_m), 32'd0);
      check("mid_mem",       32'({mwe_m, men_m}), 32'd0);
      check("mid_act_still", 32'(act_m), 32'b001);
      check("mid_writes",    32'(exp_wr.size()), 32'd191);
      @(negedge clk); #1;
      check("mid_act_drop",  32'(act_m), 32'd0);
      check("mid_owner",     32'(own_m), 32'd0);
      exp_wr.delete();
      reset = 1'b0;

      send(8'h53, fwd);
      check("s2_act",   32'(act_m), 32'b010);
      check("s2_owner", 32'(own_m), 32'd1);
      check("s2_busy",  32'(busy_m), 32'd1);
      check("s2_fwd",   32'(fwd), 32'd0);
      @(negedge clk);
      c1_done = 1;
      @(negedge clk); #1;
      check("s2_rel_act", 32'(act_m), 32'd0);
      c1_done = 0;
      @(negedge clk); #1;
      check("s2_idle", 32'(busy_m), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
